// File: rtl/ariane_axi_soc.sv
// AXI4 channel and bundle types used by the SoC masters and slaves
// (64-bit address/data, 4-bit ID, 1-bit user).
package ariane_axi_soc;

    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/mem2axi_pkg.sv
// Shared types and constants for the mem2axi_master bridge.
package mem2axi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        B_WAIT = 3'd2,
        READ   = 3'd3,
        R_WAIT = 3'd4,
        RESP   = 3'd5
    } state_e;

    localparam int unsigned AXI_DATA_WIDTH_DEF = 64;
    localparam logic [2:0]  AXI_SIZE           = 3'($clog2(AXI_DATA_WIDTH_DEF / 8));
    localparam logic [1:0]  BURST_INCR         = 2'b01;

endpackage

// File: rtl/mem2axi_master.sv
// req/gnt/rvalid memory port to single-beat AXI4 master, one transaction in flight.
// Optional MEM2AXI_ADDR_CHECK_EN: requests outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) fail locally.
module mem2axi_master
    import mem2axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter logic [3:0]  AXI_ID         = 4'h0,
    parameter logic [63:0] ADDR_BASE      = 64'h8000_0000,
    parameter logic [63:0] ADDR_SIZE      = 64'h1000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic                        busy_o,
    output ariane_axi_soc::req_t        axi_req_o,
    input  ariane_axi_soc::resp_t       axi_resp_i
);

    state_e                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH/8-1:0] be_q, be_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;

    logic aw_valid, w_valid, aw_hs, w_hs;
    logic addr_ok;

`ifdef MEM2AXI_ADDR_CHECK_EN
    // Subtract-then-compare keeps the upper bound exact even when BASE+SIZE wraps.
    assign addr_ok = (64'(addr_i) >= ADDR_BASE) && ((64'(addr_i) - ADDR_BASE) < ADDR_SIZE);
`else
    logic unused_window;
    assign addr_ok       = 1'b1;
    assign unused_window = ^{ADDR_BASE, ADDR_SIZE};
`endif

    // Response fields the bridge does not need for single-beat transfers.
    logic unused_resp;
    assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.resp[0], axi_resp_i.b.user,
                           axi_resp_i.r.id, axi_resp_i.r.resp[0], axi_resp_i.r.last,
                           axi_resp_i.r.user};

    assign aw_valid = (state_q == WRITE) && !aw_done_q;
    assign w_valid  = (state_q == WRITE) && !w_done_q;
    assign aw_hs    = aw_valid && axi_resp_i.aw_ready;
    assign w_hs     = w_valid && axi_resp_i.w_ready;

    assign gnt_o    = req_i && (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign rvalid_o = (state_q == RESP);
    assign err_o    = (state_q == RESP) && err_q;
    assign rdata_o  = rdata_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_o) begin
                    addr_d    = addr_i;
                    be_d      = be_i;
                    wdata_d   = wdata_i;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (!addr_ok) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = we_i ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = B_WAIT;
            end
            B_WAIT: begin
                if (axi_resp_i.b_valid) begin
                    err_d   = axi_resp_i.b.resp[1];
                    state_d = RESP;
                end
            end
            READ: begin
                if (axi_resp_i.ar_ready) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (axi_resp_i.r_valid) begin
                    rdata_d = axi_resp_i.r.data;
                    err_d   = axi_resp_i.r.resp[1];
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = 64'(addr_q);
        axi_req_o.aw.size  = AXI_SIZE;
        axi_req_o.aw.burst = BURST_INCR;
        axi_req_o.aw_valid = aw_valid;
        axi_req_o.w.data   = 64'(wdata_q);
        axi_req_o.w.strb   = 8'(be_q);
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid;
        axi_req_o.b_ready  = (state_q == B_WAIT);
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = 64'(addr_q);
        axi_req_o.ar.size  = AXI_SIZE;
        axi_req_o.ar.burst = BURST_INCR;
        axi_req_o.ar_valid = (state_q == READ);
        axi_req_o.r_ready  = (state_q == R_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_mem2axi_master.sv
// Bench for mem2axi_master: behavioural AXI memory slave with stall/response knobs,
// scoreboard of expected responses popped on every rvalid_o pulse.
module tb_mem2axi_master;
    import ariane_axi_soc::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [63:0] addr  = '0;
    logic [7:0]  be    = '0;
    logic [63:0] wdata = '0;
    logic        gnt, rvalid, err, busy;
    logic [63:0] rdata;
    req_t        axi_req;
    resp_t       axi_resp;

    always #5 clk = ~clk;

    mem2axi_master dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .busy_o(busy), .axi_req_o(axi_req), .axi_resp_i(axi_resp)
    );

    // ---------------- behavioural slave ----------------
    logic        aw_stall_en = 1'b0, r_hold = 1'b0;
    logic [1:0]  bresp_f = 2'b00, rresp_f = 2'b00;
    int          aw_wait;
    logic        got_aw, got_w, b_v, r_v;
    logic [63:0] aw_a, w_d, r_d;
    logic [7:0]  w_s;
    logic [1:0]  b_rsp, r_rsp;
    logic [63:0] mem [logic [63:0]];

    wire         aw_hs_s = axi_req.aw_valid && axi_resp.aw_ready;
    wire         w_hs_s  = axi_req.w_valid && axi_resp.w_ready;
    wire [63:0]  cur_a   = aw_hs_s ? axi_req.aw.addr : aw_a;
    wire [63:0]  cur_d   = w_hs_s ? axi_req.w.data : w_d;
    wire [7:0]   cur_s   = w_hs_s ? axi_req.w.strb : w_s;
    wire         both    = (got_aw || aw_hs_s) && (got_w || w_hs_s);

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a >> 3) ? mem[a >> 3] : 64'h0;
    endfunction

    always_comb begin
        axi_resp          = '0;
        axi_resp.aw_ready = !aw_stall_en || (aw_wait >= 5);
        axi_resp.w_ready  = 1'b1;
        axi_resp.ar_ready = 1'b1;
        axi_resp.b_valid  = b_v;
        axi_resp.b.resp   = b_rsp;
        axi_resp.r_valid  = r_v;
        axi_resp.r.data   = r_d;
        axi_resp.r.resp   = r_rsp;
        axi_resp.r.last   = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            got_aw <= 1'b0; got_w <= 1'b0; b_v <= 1'b0; r_v <= 1'b0; aw_wait <= 0;
        end else begin
            if (aw_hs_s) aw_wait <= 0;
            else if (axi_req.aw_valid) aw_wait <= aw_wait + 1;
            if (aw_hs_s) aw_a <= axi_req.aw.addr;
            if (w_hs_s) begin w_d <= axi_req.w.data; w_s <= axi_req.w.strb; end
            if (b_v && axi_req.b_ready) b_v <= 1'b0;
            if (both) begin
                mem[cur_a >> 3] = merge(rd(cur_a), cur_d, cur_s);
                got_aw <= 1'b0; got_w <= 1'b0; b_v <= 1'b1; b_rsp <= bresp_f;
            end else begin
                got_aw <= got_aw || aw_hs_s; got_w <= got_w || w_hs_s;
            end
            if (r_v && axi_req.r_ready) r_v <= 1'b0;
            if (axi_req.ar_valid && axi_resp.ar_ready && !r_hold) begin
                r_v <= 1'b1; r_d <= rd(axi_req.ar.addr); r_rsp <= rresp_f;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { logic [63:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    int          cyc = 0, rv_cnt = 0, last_rv_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, ar_cnt = 0;
    logic        prev_rv = 1'b0, prev_awv = 1'b0, mon_gnt = 1'b0, mon_rready = 1'b0, mon_busy = 1'b0;
    logic [4:0]  mon_valids = '0;
    logic [63:0] prev_aw_addr = '0;

    // One clock: monitor/scoreboard at the falling edge, then return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        mon_gnt    = gnt;
        mon_busy   = busy;
        mon_rready = axi_req.r_ready;
        mon_valids = {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready};
        if (gnt) chk("gnt_while_busy", busy, 0);
        if (rvalid) begin
            rv_cnt++;
            last_rv_cyc = cyc;
            chk("rvalid_width", prev_rv, 0);
            if (sb.size() == 0) chk("unexpected_rvalid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("err", err, e.err);
            end
        end
        prev_rv = rvalid;
        if (axi_req.aw_valid && prev_awv) chk("aw_stable", axi_req.aw.addr, prev_aw_addr);
        prev_awv     = axi_req.aw_valid;
        prev_aw_addr = axi_req.aw.addr;
        if (aw_hs_s) aw_hs_cyc = cyc;
        if (w_hs_s)  w_hs_cyc  = cyc;
        if (axi_req.ar_valid) ar_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [63:0] a, input logic [7:0] b, input logic [63:0] d,
                         input logic [63:0] e_rdata, input logic e_err, output int gcyc);
        int t;
        exp_t e;
        e.rdata = e_rdata; e.err = e_err;
        sb.push_back(e);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        t = 0;
        do begin cycle(); t++; end while (!mon_gnt && t < 50);
        if (!mon_gnt) chk("gnt_timeout", 0, 1);
        gcyc = cyc;
        req = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin cycle(); t++; end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    initial begin
        int g, rv0, ar0, n, t;
        int gc[4];
        logic [63:0] ra[4];
        logic [63:0] rx[4];

        repeat (3) cycle();
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, axi_req.b_ready, axi_req.r_ready}, 0);
        rst = 1'b0;
        cycle();

        // full-strobe write, read back, latency from grant
        issue(1, 64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, g);
        drain();
        chk("wr_latency", 64'(last_rv_cyc - g), 3);
        issue(0, 64'h8000_0010, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 0, g);
        drain();
        chk("rd_latency", 64'(last_rv_cyc - g), 3);

        // partial strobe
        issue(1, 64'h8000_0010, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, g);
        drain();
        issue(0, 64'h8000_0010, 8'h00, 0, 64'h0123_4567_FFFF_FFFF, 0, g);
        drain();

        // AW stalled 5 cycles while W is accepted
        aw_stall_en = 1'b1;
        rv0 = rv_cnt;
        issue(1, 64'h8000_0020, 8'hFF, 64'h1111_2222_3333_4444, 0, 0, g);
        drain();
        aw_stall_en = 1'b0;
        chk("w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
        chk("aw_stall_len", 64'(aw_hs_cyc - w_hs_cyc), 5);
        chk("one_rvalid", 64'(rv_cnt - rv0), 1);
        issue(1, 64'h8000_0018, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, g);
        drain();

        // back-to-back reads with req_i held
        ra = '{64'h8000_0010, 64'h8000_0018, 64'h8000_0020, 64'h8000_0018};
        rx = '{64'h0123_4567_FFFF_FFFF, 64'hA5A5_5A5A_0F0F_F0F0, 64'h1111_2222_3333_4444, 64'hA5A5_5A5A_0F0F_F0F0};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.rdata = rx[i]; e.err = 1'b0;
            sb.push_back(e);
        end
        n = 0; t = 0;
        req = 1'b1; we = 1'b0; addr = ra[0];
        while (n < 4 && t < 60) begin
            cycle(); t++;
            if (mon_gnt) begin
                gc[n] = cyc; n++;
                if (n < 4) addr = ra[n]; else req = 1'b0;
            end
        end
        req = 1'b0;
        chk("b2b_grants", 64'(n), 4);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(gc[i] - gc[i-1]), 4);
        drain();

        // response codes
        rresp_f = 2'b10;
        issue(0, 64'h8000_0020, 0, 0, 64'h1111_2222_3333_4444, 1, g); drain();
        rresp_f = 2'b11;
        issue(0, 64'h8000_0018, 0, 0, 64'hA5A5_5A5A_0F0F_F0F0, 1, g); drain();
        rresp_f = 2'b01;
        issue(0, 64'h8000_0020, 0, 0, 64'h1111_2222_3333_4444, 0, g); drain();
        rresp_f = 2'b00;
        bresp_f = 2'b10;
        issue(1, 64'h8000_0028, 8'hFF, 64'h1, 0, 1, g); drain();
        bresp_f = 2'b11;
        issue(1, 64'h8000_0028, 8'hFF, 64'h2, 0, 1, g); drain();
        bresp_f = 2'b01;
        issue(1, 64'h8000_0028, 8'hFF, 64'h3, 0, 0, g); drain();
        bresp_f = 2'b00;

        // address window
        ar0 = ar_cnt;
`ifdef MEM2AXI_ADDR_CHECK_EN
        issue(0, 64'h0, 0, 0, 0, 1, g); drain();
        chk("addrchk_latency", 64'(last_rv_cyc - g), 1);
        chk("addrchk_no_ar", 64'(ar_cnt - ar0), 0);
        issue(0, 64'h9000_0000, 0, 0, 0, 1, g); drain();
        issue(0, 64'h8FFF_FFF8, 0, 0, 0, 0, g); drain();
        issue(1, 64'h7FFF_FFF8, 8'hFF, 64'h5, 0, 1, g); drain();
        chk("addrchk_one_ar", 64'(ar_cnt - ar0), 1);
`else
        issue(0, 64'h0, 0, 0, 0, 0, g); drain();
        chk("low_addr_latency", 64'(last_rv_cyc - g), 3);
        chk("low_addr_ar", 64'(ar_cnt - ar0), 1);
`endif

        // reset while waiting for R
        r_hold = 1'b1;
        rv0 = rv_cnt;
        req = 1'b1; we = 1'b0; addr = 64'h8000_0010;
        t = 0;
        do begin cycle(); t++; end while (!mon_gnt && t < 50);
        req = 1'b0;
        t = 0;
        do begin cycle(); t++; end while (!mon_rready && t < 50);
        chk("reached_r_wait", mon_rready, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        r_hold = 1'b0;
        cycle();
        chk("rst_mid_busy", mon_busy, 0);
        chk("rst_mid_valids", mon_valids, 0);
        repeat (8) cycle();
        chk("rst_mid_no_rvalid", 64'(rv_cnt - rv0), 0);

        // bridge still works afterwards
        issue(0, 64'h8000_0020, 0, 0, 64'h1111_2222_3333_4444, 0, g);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
